mem_arbiter: RTL

- Two-requester arbiter that shares the single memory port of the multicycle core.
- Requester 0 is the core's control/datapath memory interface. Requester 1 is a secondary master (debug/DMA loader).
- Both sides use the same enable/busy handshake: requester raises rd_en/wr_en, memory raises busy, memory drops busy to signal completion.
- The block round-robins whole transactions between requesters and forwards exactly one requester to memory at a time.

---
 rtl/mem_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one enable/busy memory port between two requesters
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_rd_en,
  input  logic                  req0_wr_en,
  input  logic [BE_WIDTH-1:0]   req0_byte_en,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wr_data,
  output logic [DATA_WIDTH-1:0] req0_rd_data,
  output logic                  req0_busy,
  input  logic                  req1_rd_en,
  input  logic                  req1_wr_en,
  input  logic [BE_WIDTH-1:0]   req1_byte_en,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wr_data,
  output logic [DATA_WIDTH-1:0] req1_rd_data,
  output logic                  req1_busy,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [BE_WIDTH-1:0]   mem_byte_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_busy,
  output logic                  grant_valid,
  output logic                  grant_id
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, next_state;
  logic seen_busy, last_grant;
  logic req0_req, req1_req, own0, own1, owned, own_req, done, abort;
  assign req0_req = req0_rd_en | req0_wr_en;
  assign req1_req = req1_rd_en | req1_wr_en;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign owned = own0 | own1;
  assign own_req = own1 ? req1_req : req0_req;
  assign done = owned & seen_busy & ~mem_busy;
  assign abort = owned & ~seen_busy & ~own_req;
  // An unreachable encoding behaves as IDLE so the FSM always recovers.
  always_comb begin
    next_state = state;
    if (owned)
      next_state = (done || abort) ? IDLE : state;
    else
      next_state = (req0_req && (!req1_req || FIXED_PRIORITY != 0 || last_grant)) ? OWN0 :
                   req1_req ? OWN1 : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      seen_busy  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state     <= next_state;
      seen_busy <= owned & ~done & ~abort & (seen_busy | mem_busy);
      if (done) last_grant <= own1;
    end
  end
  assign mem_rd_en    = own0 ? req0_rd_en   : own1 ? req1_rd_en   : 1'b0;
  assign mem_wr_en    = own0 ? req0_wr_en   : own1 ? req1_wr_en   : 1'b0;
  assign mem_byte_en  = own0 ? req0_byte_en : own1 ? req1_byte_en : '0;
  assign mem_addr     = own0 ? req0_addr    : own1 ? req1_addr    : '0;
  assign mem_wr_data  = own0 ? req0_wr_data : own1 ? req1_wr_data : '0;
  assign req0_busy    = own0 & mem_busy;
  assign req1_busy    = own1 & mem_busy;
  assign req0_rd_data = mem_rd_data;
  assign req1_rd_data = mem_rd_data;
  assign grant_valid  = owned;
  assign grant_id     = own1;
endmodule
